// File: rtl/output_argmax.sv
// Final classification stage: scans the logit read port once per start and reports
// the argmax class, its logit, the top-1/top-2 margin and a low-confidence flag.
module output_argmax #(
    parameter int unsigned NUM_CLASSES   = 10,
    parameter int unsigned LOGIT_W       = 6,
    parameter int unsigned IDX_W         = 4,
    parameter int unsigned MARGIN_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [IDX_W-1:0]          read_addr,
    input  logic signed [LOGIT_W-1:0] read_data,
    output logic                      busy,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [IDX_W-1:0]          class_out,
    output logic signed [LOGIT_W-1:0] top_logit,
    output logic [LOGIT_W:0]          margin,
    output logic                      low_conf
);

    typedef enum logic [1:0] {StIdle, StScan, StResult} state_e;

    localparam logic [IDX_W-1:0]          LastIdx      = IDX_W'(NUM_CLASSES - 1);
    localparam logic [LOGIT_W:0]          MarginThresh = (LOGIT_W + 1)'(MARGIN_THRESH);
    localparam logic signed [LOGIT_W-1:0] MinLogit     = {1'b1, {(LOGIT_W - 1){1'b0}}};

    state_e                     state_q;
    logic signed [LOGIT_W-1:0]  top1_q, top2_q, top1_d, top2_d;
    logic [IDX_W-1:0]           top1_idx_q, top1_idx_d;
    logic [LOGIT_W:0]           margin_d;

    // Strict signed compares so that ties keep the lower index.
    always_comb begin
        top1_d     = top1_q;
        top2_d     = top2_q;
        top1_idx_d = top1_idx_q;
        if (read_data > top1_q) begin
            top2_d     = top1_q;
            top1_d     = read_data;
            top1_idx_d = read_addr;
        end else if (read_data > top2_q) begin
            top2_d = read_data;
        end
        // Sign-extend by one bit; top1 >= top2 keeps the difference non-negative.
        margin_d = {top1_d[LOGIT_W-1], top1_d} - {top2_d[LOGIT_W-1], top2_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            read_addr    <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            class_out    <= '0;
            top_logit    <= '0;
            margin       <= '0;
            low_conf     <= 1'b0;
            top1_q       <= '0;
            top2_q       <= '0;
            top1_idx_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StScan;
                        read_addr  <= '0;
                        top1_q     <= MinLogit;
                        top2_q     <= MinLogit;
                        top1_idx_q <= '0;
                        busy       <= 1'b1;
                    end
                end
                StScan: begin
                    top1_q     <= top1_d;
                    top2_q     <= top2_d;
                    top1_idx_q <= top1_idx_d;
                    if (read_addr == LastIdx) begin
                        class_out    <= top1_idx_d;
                        top_logit    <= top1_d;
                        margin       <= margin_d;
                        low_conf     <= (margin_d < MarginThresh);
                        result_valid <= 1'b1;
                        read_addr    <= '0;
                        state_q      <= StResult;
                    end else begin
                        read_addr <= read_addr + IDX_W'(1);
                    end
                end
                StResult: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax with a queue scoreboard of expected results.
module tb_output_argmax;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        read_addr;
    logic signed [5:0] read_data;
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [3:0]        class_out;
    logic signed [5:0] top_logit;
    logic [6:0]        margin;
    logic              low_conf;

    logic signed [5:0] mem [10];

    typedef struct {
        int cls;
        int top;
        int mar;
        int low;
    } res_t;

    res_t sb[$];
    res_t last;
    int   checks   = 0;
    int   failures = 0;

    output_argmax dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .class_out    (class_out),
        .top_logit    (top_logit),
        .margin       (margin),
        .low_conf     (low_conf)
    );

    always #5 clk = ~clk;

    always_comb read_data = (read_addr < 4'd10) ? mem[read_addr] : 6'sd0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int cls, input int top, input int mar, input int low);
        res_t r;
        r.cls = cls;
        r.top = top;
        r.mar = mar;
        r.low = low;
        sb.push_back(r);
    endtask

    task automatic check_fields(input string tag, input res_t e);
        check({tag, "_class"}, class_out, e.cls);
        check({tag, "_top"}, top_logit, e.top);
        check({tag, "_margin"}, margin, e.mar);
        check({tag, "_lowconf"}, low_conf, e.low);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, read_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_class"}, class_out, 0);
        check({tag, "_top"}, top_logit, 0);
        check({tag, "_margin"}, margin, 0);
        check({tag, "_lowconf"}, low_conf, 0);
    endtask

    // Called in scan cycle 1; returns in cycle 11 with the result compared.
    task automatic scan_body();
        for (int i = 0; i < 10; i++) begin
            check("scan_busy", busy, 1);
            check("scan_addr", read_addr, i);
            check("scan_valid", result_valid, 0);
            step();
        end
        check("valid_rise", result_valid, 1);
        check("result_busy", busy, 1);
        check("result_addr", read_addr, 0);
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_empty: observed=%0d expected=nonzero", sb.size());
        end
        if (sb.size() > 0) begin
            last = sb.pop_front();
            check_fields("result", last);
        end
    endtask

    task automatic scan_and_check(input logic keep_start);
        start = 1'b1;
        step();
        if (!keep_start) start = 1'b0;
        scan_body();
    endtask

    task automatic check_handshake_done();
        check("hs_valid", result_valid, 0);
        check("hs_busy", busy, 0);
        check("hs_addr", read_addr, 0);
        check_fields("retained", last);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        mem          = '{default: 6'sd0};
        #3;
        check_zero("reset");
        #10;
        rst = 1'b0;
        step();

        // Distinct logits, ready held high.
        mem = '{-6'sd3, 6'sd5, 6'sd12, -6'sd32, 6'sd0, 6'sd7, 6'sd31, 6'sd2, -6'sd1, 6'sd4};
        push(6, 31, 19, 0);
        result_ready = 1'b1;
        scan_and_check(1'b0);
        step();
        check_handshake_done();

        // Tie keeps the lower index.
        mem = '{default: 6'sd0};
        mem[2] = 6'sd9;
        mem[7] = 6'sd9;
        push(2, 9, 0, 1);
        scan_and_check(1'b0);
        step();
        check_handshake_done();

        // All at the minimum.
        mem = '{default: -6'sd32};
        push(0, -32, 0, 1);
        scan_and_check(1'b0);
        step();
        check_handshake_done();

        // Maximum margin on the last address.
        mem[9] = 6'sd31;
        push(9, 31, 63, 0);
        scan_and_check(1'b0);
        step();
        check_handshake_done();

        // Backpressure, with a start pulse in RESULT that must be ignored.
        mem = '{6'sd1, 6'sd2, 6'sd3, 6'sd4, 6'sd5, 6'sd6, 6'sd7, 6'sd8, 6'sd9, 6'sd10};
        push(9, 10, 1, 1);
        result_ready = 1'b0;
        scan_and_check(1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", result_valid, 1);
            check("bp_busy", busy, 1);
            check_fields("bp", last);
            start = (k == 2);
            step();
        end
        start        = 1'b0;
        result_ready = 1'b1;
        check("bp_valid_last", result_valid, 1);
        step();
        check_handshake_done();
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp_idle_busy", busy, 0);
        end

        // Held start: a second scan begins right after the handshake.
        mem = '{-6'sd3, 6'sd5, 6'sd12, -6'sd32, 6'sd0, 6'sd7, 6'sd31, 6'sd2, -6'sd1, 6'sd4};
        push(6, 31, 19, 0);
        push(6, 31, 19, 0);
        scan_and_check(1'b1);
        step();
        check_handshake_done();
        step();
        start = 1'b0;
        scan_body();
        step();
        check_handshake_done();
        for (int k = 0; k < 3; k++) begin
            step();
            check("held_idle_busy", busy, 0);
            check("held_idle_addr", read_addr, 0);
        end

        // Asynchronous reset mid-scan, then a fresh run.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("pre_rst_addr", read_addr, 5);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        #2;
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", result_valid, 0);
        push(6, 31, 19, 0);
        scan_and_check(1'b0);
        step();
        check_handshake_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_argmax.md
# output_argmax

Final classification stage, directly downstream of the second dense layer. When started, it walks the layer's 10-entry logit read port, tracks the largest and second-largest signed logits, and reports the winning class index, its logit, the top-1/top-2 margin and a low-confidence flag. The result is presented on a valid/ready handshake to the chip output or host interface.

## Interface
- NUM_CLASSES, 10, number of logits scanned (addresses 0..NUM_CLASSES-1)
- LOGIT_W, 6, signed logit width
- IDX_W, 4, class index / read address width
- MARGIN_THRESH, 4, unsigned; a margin strictly below this sets low_conf

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE; usually driven by the layer-2 done level
- read_addr  out  IDX_W  logit address to the layer-2 read port (registered)
- read_data  in  LOGIT_W signed  logit at read_addr; combinational in the same cycle
- busy  out  1  high in SCAN and RESULT
- result_valid  out  1  result fields are valid
- result_ready  in  1  consumer accepts the result
- class_out  out  IDX_W  argmax index
- top_logit  out  LOGIT_W signed  logit at class_out
- margin  out  LOGIT_W+1 unsigned  top1 − top2, range 0..63
- low_conf  out  1  margin < MARGIN_THRESH

## Operation
- States: IDLE, SCAN, RESULT.
- IDLE: if start=1, then idx←0, read_addr←0, top1←−2^(LOGIT_W−1), top2←−2^(LOGIT_W−1), top1_idx←0, busy←1, go to SCAN.
- SCAN, one logit per cycle. v=read_data corresponds to read_addr=idx.
  - If v > top1: top2←top1, top1←v, top1_idx←idx.
  - Else if v > top2: top2←v.
  - All comparisons are signed and strict, so ties keep the lower index.
  - If idx = NUM_CLASSES−1: latch class_out←final top1_idx, top_logit←final top1, margin←final top1−final top2 (computed in LOGIT_W+1 bits, never negative), low_conf←(margin<MARGIN_THRESH). Then result_valid←1 and go to RESULT.
  - Otherwise idx←idx+1 and read_addr←idx+1.
  - The comparison on the last cycle must be included in the latched values (use next-state values).
- RESULT: hold all result fields and result_valid=1 until result_ready=1. On that cycle clear result_valid and busy, then go to IDLE.
- After the handshake, class_out, top_logit, margin and low_conf keep their last values until the next latch.
- start is ignored in SCAN and RESULT. It is not edge-detected. If start is still high on the cycle after returning to IDLE, a new scan begins, so the upstream start level must drop first.
- read_addr never exceeds NUM_CLASSES−1. It is 0 in IDLE and RESULT.

## Timing
- Reset (async, any state): state=IDLE; read_addr, busy, result_valid, class_out, top_logit, margin, low_conf all 0; internal top1/top2/idx cleared. A reset during SCAN or RESULT discards the partial or pending result. No valid is produced.
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..NUM_CLASSES: SCAN with read_addr=0..9, one address per cycle.
- Cycle NUM_CLASSES+1 (cycle 11): result_valid=1. Start-to-valid latency is 11 cycles.
- If result_ready is already high when valid rises, the handshake completes that cycle. result_valid is high for exactly one cycle and the block is back in IDLE at cycle 12.
- result_ready while result_valid=0 has no effect.
- The upstream logits must stay stable from cycle 1 through cycle NUM_CLASSES. The block does not re-check this.

## Test plan
- Distinct logits [−3,5,12,−32,0,7,31,2,−1,4], start pulse, ready held high → valid at cycle 11 for exactly 1 cycle; class 6, top 31, margin 19, low_conf 0; read_addr sequence 0..9.
- Tie: logits all 0 except idx 2 = 9 and idx 7 = 9 → class 2, top 9, margin 0, low_conf 1.
- Extremes: all −32 → class 0, top −32, margin 0. Then idx 9 = 31, others −32 → class 9, margin 63.
- Backpressure: ready low for 5 cycles after valid → fields stable and busy=1 throughout. A start pulse in RESULT is ignored. Ready high → valid drops the next cycle, fields retained.
- Held start: start held high across a full run → a second scan begins the cycle after the handshake with the same result. Drop start → stays in IDLE.
- Reset mid-SCAN at read_addr=5 → all outputs 0 immediately (async). A later start produces a correct fresh result.
